note_disp_scan: RTL and testbench

- Time-multiplexed, N-digit seven-segment driver for musical-note display.
- Holds one note code, tone flag and blank flag per digit in an internal register file.
- Scans the digits one at a time and produces active-low segment, decimal-point and anode-select outputs.
- Sits between the note-selection logic and the board's common-anode display bank.
- Generalises the single-digit combinational note decoder to N digits with scanning and write-port storage.

---
 rtl/note_disp_scan.sv | 147 ++++++++++++++
 tb/tb_note_disp_scan.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_disp_scan.sv
// ---------------------------------------------------------------------------
// note_disp_scan
//   Time-multiplexed N-digit seven-segment driver for musical-note display.
//   Each digit stores a note code, a tone (sharp) flag and a blank flag in a
//   small register file. A prescaler divides the clock into digit slots. A
//   digit index selects which entry drives the active-low common-anode
//   outputs during each slot. All outputs are registered.
//
// Ports
//   CLK       in   system clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   ENABLE    in   scan enable; low freezes the scan and blanks all anodes
//   CLEAR     in   synchronous clear of every entry (wins over WR_EN)
//   WR_EN     in   write strobe for one digit entry
//   WR_ADDR   in   digit index to write (writes >= N_DIGITS are ignored)
//   WR_NOTA   in   note code 0..6 = C D E F G A B, 7 = rest
//   WR_TOM    in   tone flag, lights the decimal point
//   WR_BLANK  in   blank flag, forces the digit dark
//   SEG       out  active-low segments, SEG[6]=a .. SEG[0]=g
//   DP_N      out  active-low decimal point
//   AN        out  active-low one-hot anode select
// ---------------------------------------------------------------------------
module note_disp_scan #(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  localparam int ADDR_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                ENABLE,
  input  logic                CLEAR,
  input  logic                WR_EN,
  input  logic [ADDR_W-1:0]   WR_ADDR,
  input  logic [2:0]          WR_NOTA,
  input  logic                WR_TOM,
  input  logic                WR_BLANK,
  output logic [6:0]          SEG,
  output logic                DP_N,
  output logic [N_DIGITS-1:0] AN
);

  localparam int P_W = $clog2(SCAN_DIV);
  // The file is sized to the full address space so idx never indexes past it;
  // entries at or above N_DIGITS are never written and stay blank.
  localparam int N_SLOTS = 2 ** ADDR_W;

  localparam logic [P_W-1:0]    P_LAST   = P_W'(SCAN_DIV - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_DIGITS - 1);
  localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(N_DIGITS);

  // Entry layout: {nota[2:0], tom, blank}; reset value is a blanked rest.
  localparam logic [4:0] ENT_RESET = {3'd7, 1'b0, 1'b1};

  logic [4:0]          ent_q [N_SLOTS];
  logic [4:0]          ent_d [N_SLOTS];
  logic [P_W-1:0]      p_q, p_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_n_q, dp_n_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic                wr_in_range_s;
  logic [4:0]          cur_ent_s;

  // Active-low glyph for a note code.
  function automatic logic [6:0] glyph(input logic [2:0] nota);
    logic [6:0] g;
    case (nota)
      3'd0:    g = 7'h31;  // C
      3'd1:    g = 7'h42;  // d
      3'd2:    g = 7'h30;  // E
      3'd3:    g = 7'h38;  // F
      3'd4:    g = 7'h21;  // G
      3'd5:    g = 7'h08;  // A
      3'd6:    g = 7'h60;  // b
      default: g = 7'h7E;  // rest: middle bar only
    endcase
    return g;
  endfunction

  assign wr_in_range_s = ({1'b0, WR_ADDR} < ADDR_LIM);
  assign cur_ent_s     = ent_q[idx_q];

  // Next-state logic for the register file, scan counters and outputs.
  always_comb begin
    ent_d = ent_q;
    p_d   = p_q;
    idx_d = idx_q;

    if (CLEAR) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        ent_d[i] = ENT_RESET;
      end
    end else if (WR_EN && wr_in_range_s) begin
      ent_d[WR_ADDR] = {WR_NOTA, WR_TOM, WR_BLANK};
    end else begin
      ent_d = ent_q;
    end

    if (ENABLE) begin
      if (p_q == P_LAST) begin
        p_d   = '0;
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + ADDR_W'(1);
      end else begin
        p_d   = p_q + P_W'(1);
      end
    end else begin
      p_d   = p_q;
      idx_d = idx_q;
    end

    // The first cycle of every slot (p == 0) keeps all anodes off so the
    // previous digit's segments never ghost onto the newly selected one.
    for (int i = 0; i < N_DIGITS; i++) begin
      an_d[i] = !(ENABLE && (p_q != '0) && (idx_q == ADDR_W'(i)));
    end

    seg_d  = cur_ent_s[0] ? 7'h7F : glyph(cur_ent_s[4:2]);
    dp_n_d = ~(cur_ent_s[1] & ~cur_ent_s[0]);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        ent_q[i] <= ENT_RESET;
      end
      p_q    <= '0;
      idx_q  <= '0;
      seg_q  <= 7'h7F;
      dp_n_q <= 1'b1;
      an_q   <= '1;
    end else begin
      ent_q  <= ent_d;
      p_q    <= p_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      dp_n_q <= dp_n_d;
      an_q   <= an_d;
    end
  end

  assign SEG  = seg_q;
  assign DP_N = dp_n_q;
  assign AN   = an_q;

endmodule

// File: tb/tb_note_disp_scan.sv
// ---------------------------------------------------------------------------
// tb_note_disp_scan
//   Three instances (4 digits / div 4, 3 digits / div 3, 1 digit / div 2)
//   share one stimulus stream. A behavioural model tracks, per instance, the
//   digit entries and the number of enabled cycles since reset; slot position
//   and digit follow from plain division of that count. A compare process
//   checks every instance on each falling edge; directed sections pin the
//   model with literal values before a randomized run.
// ---------------------------------------------------------------------------
module tb_note_disp_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, clear, wr_en;
  logic [1:0] wr_addr;
  logic [2:0] wr_nota;
  logic       wr_tom, wr_blank;

  logic [6:0] seg0, seg1, seg2;
  logic       dp0, dp1, dp2;
  logic [3:0] an0;
  logic [2:0] an1;
  logic [0:0] an2;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  note_disp_scan #(.N_DIGITS(4), .SCAN_DIV(4)) dut0 (
    .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .CLEAR(clear), .WR_EN(wr_en),
    .WR_ADDR(wr_addr), .WR_NOTA(wr_nota), .WR_TOM(wr_tom), .WR_BLANK(wr_blank),
    .SEG(seg0), .DP_N(dp0), .AN(an0));

  note_disp_scan #(.N_DIGITS(3), .SCAN_DIV(3)) dut1 (
    .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .CLEAR(clear), .WR_EN(wr_en),
    .WR_ADDR(wr_addr), .WR_NOTA(wr_nota), .WR_TOM(wr_tom), .WR_BLANK(wr_blank),
    .SEG(seg1), .DP_N(dp1), .AN(an1));

  note_disp_scan #(.N_DIGITS(1), .SCAN_DIV(2)) dut2 (
    .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .CLEAR(clear), .WR_EN(wr_en),
    .WR_ADDR(wr_addr[0:0]), .WR_NOTA(wr_nota), .WR_TOM(wr_tom), .WR_BLANK(wr_blank),
    .SEG(seg2), .DP_N(dp2), .AN(an2));

  // ---------------- behavioural model ----------------
  logic [2:0]  m_nota  [3][16];
  logic        m_tom   [3][16];
  logic        m_blank [3][16];
  int          ecnt    [3];
  logic [15:0] exp_an  [3];
  logic [6:0]  exp_seg [3];
  logic        exp_dp  [3];

  function automatic int nd(input int k);
    return (k == 0) ? 4 : (k == 1) ? 3 : 1;
  endfunction

  function automatic int sd(input int k);
    return (k == 0) ? 4 : (k == 1) ? 3 : 2;
  endfunction

  function automatic int aw(input int k);
    return (k == 2) ? 1 : 2;
  endfunction

  function automatic int cur_digit(input int k);
    return (ecnt[k] / sd(k)) % nd(k);
  endfunction

  function automatic int eff_addr(input int k);
    return int'(wr_addr) % (1 << aw(k));
  endfunction

  function automatic logic [6:0] note_glyph(input logic [2:0] n);
    case (n)
      3'd0:    return 7'h31;
      3'd1:    return 7'h42;
      3'd2:    return 7'h30;
      3'd3:    return 7'h38;
      3'd4:    return 7'h21;
      3'd5:    return 7'h08;
      3'd6:    return 7'h60;
      default: return 7'h7E;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        ecnt[k]    <= 0;
        exp_an[k]  <= 16'hFFFF;
        exp_seg[k] <= 7'h7F;
        exp_dp[k]  <= 1'b1;
        for (int d = 0; d < 16; d++) begin
          m_nota[k][d]  <= 3'd7;
          m_tom[k][d]   <= 1'b0;
          m_blank[k][d] <= 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        exp_an[k]  <= (enable && (ecnt[k] % sd(k)) != 0) ? ~(16'd1 << cur_digit(k)) : 16'hFFFF;
        exp_seg[k] <= m_blank[k][cur_digit(k)] ? 7'h7F : note_glyph(m_nota[k][cur_digit(k)]);
        exp_dp[k]  <= ~(m_tom[k][cur_digit(k)] & ~m_blank[k][cur_digit(k)]);
        if (enable) ecnt[k] <= ecnt[k] + 1;
        if (clear) begin
          for (int d = 0; d < 16; d++) begin
            m_nota[k][d]  <= 3'd7;
            m_tom[k][d]   <= 1'b0;
            m_blank[k][d] <= 1'b1;
          end
        end else if (wr_en && eff_addr(k) < nd(k)) begin
          m_nota[k][eff_addr(k)]  <= wr_nota;
          m_tom[k][eff_addr(k)]   <= wr_tom;
          m_blank[k][eff_addr(k)] <= wr_blank;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("m0_an",  {28'd0, an0},  {16'd0, exp_an[0] & 16'h000F});
      chk("m0_seg", {25'd0, seg0}, {25'd0, exp_seg[0]});
      chk("m0_dp",  {31'd0, dp0},  {31'd0, exp_dp[0]});
      chk("m1_an",  {29'd0, an1},  {16'd0, exp_an[1] & 16'h0007});
      chk("m1_seg", {25'd0, seg1}, {25'd0, exp_seg[1]});
      chk("m1_dp",  {31'd0, dp1},  {31'd0, exp_dp[1]});
      chk("m2_an",  {31'd0, an2},  {16'd0, exp_an[2] & 16'h0001});
      chk("m2_seg", {25'd0, seg2}, {25'd0, exp_seg[2]});
      chk("m2_dp",  {31'd0, dp2},  {31'd0, exp_dp[2]});
    end
  end

  task automatic do_write(input logic [1:0] a, input logic [2:0] n, input logic t, input logic b);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_nota = n; wr_tom = t; wr_blank = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int found;
    int hits_c;
    int hits_a;
    logic [3:0] prev;

    enable = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_addr = 2'd0;
    wr_nota = 3'd0; wr_tom = 1'b0; wr_blank = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    chk("rst_an0",  {28'd0, an0},  32'hF);
    chk("rst_seg0", {25'd0, seg0}, 32'h7F);
    chk("rst_dp0",  {31'd0, dp0},  32'h1);

    // Blank scan: slot pattern with one dark cycle per slot.
    rst_n = 1'b1; enable = 1'b1;
    @(negedge clk); chk("an_slot0_dark", {28'd0, an0}, 32'hF);
    @(negedge clk); chk("an_slot0", {28'd0, an0}, 32'hE);
                    chk("an1dig_low", {31'd0, an2}, 32'h0);
    repeat (3) @(negedge clk);
    chk("an_slot1_dark", {28'd0, an0}, 32'hF);
    chk("an1dig_high", {31'd0, an2}, 32'h1);
    @(negedge clk); chk("an_slot1", {28'd0, an0}, 32'hD);
    chk("seg_all_blank", {25'd0, seg0}, 32'h7F);

    // Digit 0 = C, digit 2 = A sharp.
    do_write(2'd0, 3'd0, 1'b0, 1'b0);
    do_write(2'd2, 3'd5, 1'b1, 1'b0);
    hits_c = 0; hits_a = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (an0 == 4'hE) begin
        hits_c++;
        chk("c_seg", {25'd0, seg0}, 32'h31);
        chk("c_dp",  {31'd0, dp0},  32'h1);
      end else if (an0 == 4'hB) begin
        hits_a++;
        chk("a_seg", {25'd0, seg0}, 32'h08);
        chk("a_dp",  {31'd0, dp0},  32'h0);
      end
    end
    chk("c_seen", (hits_c > 0) ? 32'd1 : 32'd0, 32'd1);
    chk("a_seen", (hits_a > 0) ? 32'd1 : 32'd0, 32'd1);

    // Digit 1 = visible rest; freeze the scan mid-slot.
    do_write(2'd1, 3'd7, 1'b0, 1'b0);
    found = 0; prev = an0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (an0 == 4'hD && prev == 4'hF) found = 1;
      else prev = an0;
    end
    chk("wait_digit1", found, 32'd1);
    chk("rest_seg", {25'd0, seg0}, 32'h7E);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("frozen_an", {28'd0, an0}, 32'hF);
    end
    enable = 1'b1;
    @(negedge clk); chk("resume_a", {28'd0, an0}, 32'hD);
    @(negedge clk); chk("resume_b", {28'd0, an0}, 32'hD);
    @(negedge clk); chk("resume_dark", {28'd0, an0}, 32'hF);

    // CLEAR beats a simultaneous write.
    @(negedge clk);
    clear = 1'b1; wr_en = 1'b1; wr_addr = 2'd3; wr_nota = 3'd4; wr_tom = 1'b0; wr_blank = 1'b0;
    @(negedge clk);
    clear = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("clear_seg", {25'd0, seg0}, 32'h7F);
      chk("clear_dp",  {31'd0, dp0},  32'h1);
    end

    // Address 3 is out of range for the 3-digit and 1-digit instances.
    do_write(2'd3, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk("oor_seg1", {25'd0, seg1}, 32'h7F);
      chk("oor_seg2", {25'd0, seg2}, 32'h7F);
    end

    // Async reset mid-slot with a digit lit.
    do_write(2'd0, 3'd1, 1'b1, 1'b0);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (an0 == 4'hE) found = 1;
    end
    chk("wait_lit", found, 32'd1);
    chk("d_seg", {25'd0, seg0}, 32'h42);
    chk("d_dp",  {31'd0, dp0},  32'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an",  {28'd0, an0},  32'hF);
    chk("arst_seg", {25'd0, seg0}, 32'h7F);
    chk("arst_dp",  {31'd0, dp0},  32'h1);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); chk("restart_dark", {28'd0, an0}, 32'hF);
    @(negedge clk); chk("restart_idx0", {28'd0, an0}, 32'hE);

    // Randomized run.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      enable   = ($urandom_range(0, 7) != 0);
      clear    = ($urandom_range(0, 49) == 0);
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = 2'($urandom_range(0, 3));
      wr_nota  = 3'($urandom_range(0, 7));
      wr_tom   = 1'($urandom_range(0, 1));
      wr_blank = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
